rs_syndrome: RTL and testbench

Front end of the RS(255,239) decoder over GF(2^8). It is the receive-side counterpart of the systematic parity encoder chain.
- Accepts one received codeword symbol per valid cycle, highest-degree symbol first (r254 ... r0).
- Accumulates the 16 syndromes S_i = r(alpha^i), i = 0..15, by Horner recursion.
- Presents all 16 syndromes plus a nonzero flag one cycle after the last symbol, for the downstream key-equation solver.

---
 rtl/rs_pkg.sv | 45 ++++
 rtl/rs_synd_cell.sv | 55 +++++
 rtl/rs_syndrome.sv | 133 +++++++++++++
 tb/tb_rs_syndrome.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg
// Shared definitions for the RS(255,239) encoder/decoder blocks over
// GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
//
// Contents:
//   GF_POLY        low byte of the field polynomial (x^8 term implicit)
//   N_SYM, N_PAR   codeword length and parity count in symbols
//   SYM_W          symbol width
//   synd_state_e   syndrome front-end FSM states
//   gf_xtime       multiply a field element by alpha
//   gf_mul_const   multiply a field element by alpha^exp (exp constant)
// ---------------------------------------------------------------------------
package rs_pkg;

  localparam logic [7:0] GF_POLY = 8'h1D;
  localparam int         N_SYM   = 255;
  localparam int         N_PAR   = 16;
  localparam int         SYM_W   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } synd_state_e;

  // Multiply by alpha: shift left, fold the x^8 overflow back in.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    gf_xtime = {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // Multiply by alpha^exp. With a constant exp this unrolls into a fixed
  // XOR matrix; the loop bound is static so synthesis can flatten it.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] sym,
                                              input int         exp);
    logic [7:0] r;
    r = sym;
    for (int k = 0; k < N_SYM; k++) begin
      if (k < exp) begin
        r = gf_xtime(r);
      end
    end
    gf_mul_const = r;
  endfunction

endpackage

// File: rtl/rs_synd_cell.sv
// ---------------------------------------------------------------------------
// rs_synd_cell
// One syndrome accumulator S_IDX = r(alpha^IDX), evaluated by Horner's rule
// as symbols arrive highest degree first.
//
// Ports:
//   clk         clock
//   rst         synchronous active-low reset, clears the accumulator
//   load_i      start a new codeword: accumulator takes data_i directly
//   update_i    Horner step: accumulator takes acc * alpha^IDX ^ data_i
//   data_i      received symbol
//   acc_next_o  value of the Horner step for this cycle's symbol, used by
//               the top level to capture the final syndrome without waiting
//               for the accumulator to register it
// ---------------------------------------------------------------------------
module rs_synd_cell
  import rs_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             update_i,
  input  logic [SYM_W-1:0] data_i,
  output logic [SYM_W-1:0] acc_next_o
);

  logic [SYM_W-1:0] acc_q;
  logic [SYM_W-1:0] acc_d;
  logic [SYM_W-1:0] scaled;

  // Constant multiply; for IDX = 0 this collapses to a plain wire.
  assign scaled     = gf_mul_const(acc_q, IDX);
  assign acc_next_o = scaled ^ data_i;

  // Load wins over update so a restart never folds in stale state.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = data_i;
    end else if (update_i) begin
      acc_d = acc_next_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/rs_syndrome.sv
// ---------------------------------------------------------------------------
// rs_syndrome
// Receive-side front end of the RS(255,239) decoder. Accepts one symbol per
// valid cycle (r254 first), accumulates the 16 syndromes S_0..S_15 and
// presents them, plus a nonzero flag, one cycle after r0 is accepted.
//
// Ports:
//   clk         clock
//   rst         synchronous active-low reset
//   in_valid    in_data carries a symbol this cycle
//   in_sop      first symbol of a codeword (qualified by in_valid)
//   in_data     received symbol
//   synd_valid  one-cycle pulse: synd_out / synd_nz updated
//   synd_out    S0 in [7:0] ... S15 in [127:120]; held until next codeword
//   synd_nz     OR of all syndromes (codeword contains errors)
//   frame_err   one-cycle pulse: in_sop arrived mid-codeword
// ---------------------------------------------------------------------------
module rs_syndrome
  import rs_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic [SYM_W-1:0]       in_data,
  output logic                   synd_valid,
  output logic [N_PAR*SYM_W-1:0] synd_out,
  output logic                   synd_nz,
  output logic                   frame_err
);

  localparam logic [7:0] LAST_CNT = 8'(N_SYM - 1);

  synd_state_e state_q, state_d;
  logic [7:0]  count_q, count_d;

  logic [N_PAR*SYM_W-1:0] synd_q;
  logic                   syndNz_q;
  logic                   syndValid_q, syndValid_d;
  logic                   frameErr_q, frameErr_d;

  logic                   loadEn;
  logic                   updEn;
  logic                   capture;
  logic [N_PAR*SYM_W-1:0] syndNext;

  // One accumulator per root alpha^0 .. alpha^(N_PAR-1).
  for (genvar i = 0; i < N_PAR; i++) begin : g_cell
    rs_synd_cell #(
      .IDX (i)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .load_i     (loadEn),
      .update_i   (updEn),
      .data_i     (in_data),
      .acc_next_o (syndNext[i*SYM_W +: SYM_W])
    );
  end

  // Next-state and control. A mid-codeword in_sop restarts the
  // accumulators immediately so the new codeword loses no symbol.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    loadEn      = 1'b0;
    updEn       = 1'b0;
    capture     = 1'b0;
    syndValid_d = 1'b0;
    frameErr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_sop) begin
          loadEn  = 1'b1;
          count_d = 8'd1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          if (in_sop) begin
            frameErr_d = 1'b1;
            loadEn     = 1'b1;
            count_d    = 8'd1;
          end else begin
            updEn = 1'b1;
            if (count_q == LAST_CNT) begin
              capture     = 1'b1;
              syndValid_d = 1'b1;
              count_d     = 8'd0;
              state_d     = ST_IDLE;
            end else begin
              count_d = count_q + 8'd1;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 8'd0;
      end
    endcase
  end

  // State, counter and the output register. The output register is
  // separate from the accumulators so a back-to-back codeword can begin
  // loading while the previous syndromes are being presented.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      count_q     <= 8'd0;
      synd_q      <= '0;
      syndNz_q    <= 1'b0;
      syndValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      syndValid_q <= syndValid_d;
      frameErr_q  <= frameErr_d;
      if (capture) begin
        synd_q   <= syndNext;
        syndNz_q <= |syndNext;
      end
    end
  end

  assign synd_valid = syndValid_q;
  assign synd_out   = synd_q;
  assign synd_nz    = syndNz_q;
  assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_rs_syndrome.sv
// ---------------------------------------------------------------------------
// tb_rs_syndrome
// Drives codewords into rs_syndrome and scores the syndrome outputs against
// a direct polynomial-evaluation model of S_i = r(alpha^i).
// ---------------------------------------------------------------------------
module tb_rs_syndrome;
  import rs_pkg::*;

  localparam int NS = N_SYM;
  localparam int NP = N_PAR;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_sop;
  logic [7:0]     in_data;
  logic           synd_valid;
  logic [NP*8-1:0] synd_out;
  logic           synd_nz;
  logic           frame_err;

  typedef struct {
    logic [NP*8-1:0] synd;
    logic            nz;
    int              cyc;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] frame [NS];
  logic [7:0] alphaPow [NS];
  int         cyc = 0;
  int         nChecks = 0;
  int         nFail = 0;
  int         frameErrSeen = 0;

  rs_syndrome dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_data    (in_data),
    .synd_valid (synd_valid),
    .synd_out   (synd_out),
    .synd_nz    (synd_nz),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generic GF(2^8) multiply, shift-and-add with reduction by 0x11D.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] r;
    aa = {1'b0, a};
    r  = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r = r ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11D;
    end
    return r;
  endfunction

  // Reference syndromes: frame[p] is the coefficient of x^(254-p).
  function automatic logic [NP*8-1:0] refSynd();
    logic [NP*8-1:0] s;
    logic [7:0]      acc;
    s = '0;
    for (int i = 0; i < NP; i++) begin
      acc = 8'h00;
      for (int p = 0; p < NS; p++) begin
        acc = acc ^ gfMul(frame[p], alphaPow[(i * (NS - 1 - p)) % NS]);
      end
      s[i*8 +: 8] = acc;
    end
    return s;
  endfunction

  // Systematic encoder: random message, parity = remainder of m(x)x^16 / g(x).
  task automatic encodeFrame();
    logic [7:0] g [NP+1];
    logic [7:0] c [NS];
    logic [7:0] coef;
    for (int k = 0; k <= NP; k++) g[k] = 8'h00;
    g[0] = 8'h01;
    for (int i = 0; i < NP; i++) begin
      for (int k = NP; k >= 1; k--) g[k] = g[k-1] ^ gfMul(g[k], alphaPow[i]);
      g[0] = gfMul(g[0], alphaPow[i]);
    end
    for (int d = 0; d < NS; d++) c[d] = (d >= NP) ? 8'($urandom) : 8'h00;
    for (int d = 0; d < NS; d++) frame[NS-1-d] = c[d];
    for (int d = NS - 1; d >= NP; d--) begin
      coef = c[d];
      for (int k = 0; k <= NP; k++) c[d-NP+k] = c[d-NP+k] ^ gfMul(coef, g[k]);
    end
    for (int d = 0; d < NP; d++) frame[NS-1-d] = c[d];
  endtask

  task automatic clearFrame();
    for (int p = 0; p < NS; p++) frame[p] = 8'h00;
  endtask

  task automatic randomFrame();
    for (int p = 0; p < NS; p++) frame[p] = 8'($urandom);
  endtask

  task automatic checkOutput(input string name, input logic [NP*8-1:0] act,
                             input logic [NP*8-1:0] want);
    nChecks++;
    if (act !== want) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Sends the first nSym symbols of frame with in_sop on the first; a full
  // codeword pushes its expected syndromes and presentation cycle.
  task automatic applyStimulus(input int nSym, input int gapPct);
    exp_t e;
    for (int p = 0; p < nSym; p++) begin
      for (int g = 0; g < 3 && $urandom_range(0, 99) < gapPct; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = ($urandom_range(0, 1) == 1);
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_sop   = (p == 0);
      in_data  = frame[p];
    end
    if (nSym == NS) begin
      e.synd = refSynd();
      e.nz   = |e.synd;
      e.cyc  = cyc + 1;
      expQ.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_data  = 8'h00;
    end
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 20 && expQ.size() != 0; k++) @(negedge clk);
    checkOutput("scoreboard drain", 128'(expQ.size()), 128'd0);
  endtask

  // Monitor: pops an expectation for every synd_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      if (frame_err === 1'b1) frameErrSeen++;
      if (synd_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected synd_valid", 128'd1, 128'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("synd_out", synd_out, e.synd);
          checkOutput("synd_nz", 128'(synd_nz), 128'(e.nz));
          checkOutput("latency cycle", 128'(cyc), 128'(e.cyc));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int feBase;
    alphaPow[0] = 8'h01;
    for (int k = 1; k < NS; k++) alphaPow[k] = gfMul(alphaPow[k-1], 8'h02);

    rst = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset synd_valid", 128'(synd_valid), 128'd0);
    checkOutput("reset synd_out", synd_out, 128'd0);
    checkOutput("reset synd_nz", 128'(synd_nz), 128'd0);
    checkOutput("reset frame_err", 128'(frame_err), 128'd0);
    rst = 1'b1;
    idle(2);

    $display("[TB] all-zero codeword");
    clearFrame();
    applyStimulus(NS, 0);
    idle(3);

    $display("[TB] r0 = 1");
    clearFrame(); frame[NS-1] = 8'h01;
    applyStimulus(NS, 0);
    idle(3);

    $display("[TB] r1 = 1");
    clearFrame(); frame[NS-2] = 8'h01;
    applyStimulus(NS, 0);
    idle(3);

    $display("[TB] encoded codewords with gaps");
    for (int t = 0; t < 2; t++) begin
      encodeFrame();
      applyStimulus(NS, 30);
      idle(2);
    end

    $display("[TB] back-to-back codewords");
    feBase = frameErrSeen;
    clearFrame();
    applyStimulus(NS, 0);
    frame[NS-2] = 8'h01;
    applyStimulus(NS, 0);
    idle(3);
    checkOutput("back-to-back frame_err", 128'(frameErrSeen - feBase), 128'd0);

    $display("[TB] restart at count 100");
    feBase = frameErrSeen;
    clearFrame();
    applyStimulus(100, 10);
    applyStimulus(NS, 10);
    idle(3);
    checkOutput("restart frame_err pulses", 128'(frameErrSeen - feBase), 128'd1);
    waitDrain();

    $display("[TB] random codeword then reset at count 50");
    randomFrame();
    applyStimulus(NS, 20);
    idle(3);
    applyStimulus(50, 0);
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset synd_valid", 128'(synd_valid), 128'd0);
    checkOutput("midreset synd_out", synd_out, 128'd0);
    checkOutput("midreset synd_nz", 128'(synd_nz), 128'd0);
    checkOutput("midreset frame_err", 128'(frame_err), 128'd0);
    rst = 1'b1;
    idle(300);

    $display("[TB] random codewords after reset");
    for (int t = 0; t < 3; t++) begin
      randomFrame();
      applyStimulus(NS, 15);
    end
    idle(3);

    waitDrain();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
